alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one ALU between two requesters with a valid/ready handshake on each port.
//  Requester 0 is the execute-stage operation port; requester 1 is the branch-target / auxiliary port.
//  Arbitration is round-robin. Grants are registered into a single-entry result stage.
//  Each accepted result is returned with its requester ID on a valid/ready response port.
// PARAMETERS
//  WIDTH       32   operand/result width in bits (power of 2, >= 8)
//  SHAMT_W     5    shift-amount bits taken from operand b; must equal log2(WIDTH)
// PORTS
//  clk         in   1        rising-edge clock
//  rst         in   1        synchronous, active-high reset
//  req0_valid  in   1        requester 0 has an operation
//  req0_ready  out  1        requester 0 operation accepted this cycle
//  req0_ctrl   in   3        ALU control code for requester 0 (alu_pkg encoding)
//  req0_a      in   WIDTH    operand a, requester 0
//  req0_b      in   WIDTH    operand b, requester 0
//  req1_valid / req1_ready / req1_ctrl / req1_a / req1_b   same as req0_*, for requester 1
//  rsp_valid   out  1        result register holds a valid result
//  rsp_ready   in   1        consumer takes result this cycle
//  rsp_id      out  1        requester that issued the result
//  rsp_result  out  WIDTH    ALU result
//  rsp_zero    out  1        1 when rsp_result == 0 (branch compare)
// BEHAVIOUR
//  - Reset: rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, state=EMPTY, last_grant=1 (req0 wins first tie).
//    A reset mid-operation drops any held result; no response is produced for it.
//  - Ops: ADD=000 a+b, SHL=001 a<<b[SHAMT_W-1:0], SUB=010 a-b, XOR=100, SHR=101 logical a>>b[SHAMT_W-1:0],
//    OR=110, AND=111. NOTUSED=011 gives result 0. Arithmetic is modulo 2^WIDTH; no overflow flag.
//  - Output FSM: EMPTY (no result held) and FULL (result held).
//    can_accept = (state==EMPTY) | rsp_ready.
//  - Arbitration (combinational):
//    - Only one valid requester: it is granted.
//    - Both valid: grant the requester != last_grant.
//    - Neither valid: no grant.
//    reqN_ready = grantN & can_accept. At most one ready per cycle.
//    reqN_ready may depend combinationally on rsp_ready and reqN_valid.
//  - Accept (valid & ready on port N):
//    - Capture ALU(ctrlN, aN, bN) into rsp_result, N into rsp_id, and (result==0) into rsp_zero.
//    - Set last_grant = N.
//    - The result is visible at rsp_valid the next cycle (latency 1 cycle).
//  - FSM transitions:
//    - EMPTY + accept -> FULL; EMPTY + no accept -> EMPTY.
//    - FULL + rsp_ready + accept -> FULL: back-to-back, new result replaces old, throughput 1 per cycle.
//    - FULL + rsp_ready + no accept -> EMPTY.
//    - FULL + !rsp_ready -> FULL, and rsp_* stay stable.
//  - rsp_* only change on accept or reset. rsp_valid = (state==FULL).
//  - Requester inputs are sampled only on the accept cycle.
//    A requester must hold valid/ctrl/a/b until it sees ready.
//  - last_grant is unchanged in cycles with no accept (stall or idle).
//    With both requesters continuously valid, grants strictly alternate.
// STRUCTURE
//  - Package alu_pkg: 3-bit alu_ctrl_t and the localparams ADD, SHL, SUB, NOTUSED, XOR, SHR, OR, AND.
//    The control decoder and this block both import it.
//  - Sub-module alu_core: purely combinational. Inputs ctrl, a, b; outputs result, zero. Instantiated once.
//    The operand mux selects the granted port in front of it.
//  - This block contains the arbiter, the 2-state output FSM and the result register.
// TESTING
//  1 Reset: hold rst 2 cycles with both valid=1 -> all ready=0, rsp_valid=0. First cycle after reset grants req0.
//  2 Single op: req0 ADD a=5 b=7, rsp_ready=1 -> req0_ready same cycle.
//    Next cycle: rsp_valid=1, id=0, result=12, zero=0.
//  3 Round-robin: both valid every cycle, rsp_ready=1.
//    req0 SUB 9-9, req1 SHL 1<<4 -> grants 0,1,0,1.
//    Results: (id0, 0, zero=1), then (id1, 16).
//  4 Backpressure: FULL with rsp_ready=0 for 3 cycles, req1 valid ->
//    req1_ready=0 and rsp_* stable for the 3 cycles.
//    rsp_ready=1 -> req1 accepted that same cycle; its result appears the next cycle.
//  5 Shift/edge: SHR a=0x8000_0000 b=0x23 -> 0x1000_0000 (only b[4:0]=3 used).
//    SUB 0-1 -> 0xFFFF_FFFF. NOTUSED -> 0, zero=1.
//  6 Reset mid-op: assert rst while FULL and both valid ->
//    next cycle rsp_valid=0, and req0 wins the next tie.

Source files
------------

// File: rtl/alu_pkg.sv
// Purpose: shared ALU control encoding and result-stage state type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

    typedef logic [2:0] alu_ctrl_t;

    localparam alu_ctrl_t ADD     = 3'b000;
    localparam alu_ctrl_t SHL     = 3'b001;
    localparam alu_ctrl_t SUB     = 3'b010;
    localparam alu_ctrl_t NOTUSED = 3'b011;
    localparam alu_ctrl_t XOR     = 3'b100;
    localparam alu_ctrl_t SHR     = 3'b101;
    localparam alu_ctrl_t OR      = 3'b110;
    localparam alu_ctrl_t AND     = 3'b111;

    // Result stage occupancy: EMPTY has nothing held, FULL presents a result.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } rsp_state_t;

endpackage

// File: rtl/alu_core.sv
// Purpose: combinational ALU shared by both requesters.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller registers the result.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  alu_ctrl_t        ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    logic [SHAMT_W-1:0] w_shamt;

    // Only the low bits of b count as a shift amount; upper bits are ignored.
    assign w_shamt = b[SHAMT_W-1:0];

    // Operation select; the unused code deliberately yields zero.
    always_comb begin
        result = '0;
        case (ctrl)
            ADD:     result = a + b;
            SHL:     result = a << w_shamt;
            SUB:     result = a - b;
            XOR:     result = a ^ b;
            SHR:     result = a >> w_shamt;
            OR:      result = a | b;
            AND:     result = a & b;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// Purpose: round-robin share of one ALU between two valid/ready requesters.
// Latency: 1 cycle from accept to rsp_valid; one result per cycle sustained.
// Backpressure: rsp_ready low holds the result and drops both reqN_ready.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  alu_ctrl_t        req0_ctrl,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  alu_ctrl_t        req1_ctrl,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero
);

    rsp_state_t       r_state;
    logic             r_last_grant;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_result;
    logic             r_rsp_zero;

    logic             w_can_accept;
    logic             w_grant0;
    logic             w_grant1;
    logic             w_accept;
    alu_ctrl_t        w_ctrl;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_result;
    logic             w_zero;

    // The slot is free when empty or when the held result leaves this cycle.
    assign w_can_accept = (r_state == EMPTY) | rsp_ready;

    // Lone requester wins; on a tie the one not granted last time wins.
    assign w_grant0 = req0_valid & (~req1_valid | r_last_grant);
    assign w_grant1 = req1_valid & (~req0_valid | ~r_last_grant);

    // Nothing is accepted while reset is held, so no operation is lost.
    assign req0_ready = w_grant0 & w_can_accept & ~rst;
    assign req1_ready = w_grant1 & w_can_accept & ~rst;
    assign w_accept   = req0_ready | req1_ready;

    // Operand mux in front of the single ALU follows the grant.
    assign w_ctrl = w_grant1 ? req1_ctrl : req0_ctrl;
    assign w_a    = w_grant1 ? req1_a    : req0_a;
    assign w_b    = w_grant1 ? req1_b    : req0_b;

    alu_core #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_alu_core (
        .ctrl   (w_ctrl),
        .a      (w_a),
        .b      (w_b),
        .result (w_result),
        .zero   (w_zero)
    );

    // Output FSM plus result register; rsp_* only move on accept or reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= EMPTY;
            r_last_grant <= 1'b1;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
        end else begin
            case (r_state)
                EMPTY:   if (w_accept) r_state <= FULL;
                FULL:    if (rsp_ready && !w_accept) r_state <= EMPTY;
                default: r_state <= EMPTY;
            endcase
            if (w_accept) begin
                r_last_grant <= req1_ready;
                r_rsp_id     <= req1_ready;
                r_rsp_result <= w_result;
                r_rsp_zero   <= w_zero;
            end
        end
    end

    assign rsp_valid  = (r_state == FULL);
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_zero   = r_rsp_zero;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Purpose: directed plus randomized check of alu_share_arbiter against a reference model.
// Latency: model expects results one cycle after the accepting edge.
// Backpressure: random rsp_ready stalls, requesters hold operations until ready.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    logic        clk;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [2:0]  req0_ctrl, req1_ctrl;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_zero;
    logic [31:0] rsp_result;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    bit          m_init = 0;
    bit          m_full, m_id, m_zero, m_last;
    logic [31:0] m_res;

    alu_share_arbiter #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_ctrl  (req0_ctrl),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_ctrl  (req1_ctrl),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (c)
            3'd0:    return a + b;
            3'd1:    return a << sh;
            3'd2:    return a - b;
            3'd4:    return a ^ b;
            3'd5:    return a >> sh;
            3'd6:    return a | b;
            3'd7:    return a & b;
            default: return 32'd0;
        endcase
    endfunction

    // One clock: drive inputs, check outputs against the model, advance the model.
    task automatic step(input bit r,
                        input bit v0, input logic [2:0] c0, input logic [31:0] a0, input logic [31:0] b0,
                        input bit v1, input logic [2:0] c1, input logic [31:0] a1, input logic [31:0] b1,
                        input bit rr, output bit g0, output bit g1);
        bit room, win1, e0, e1;
        @(negedge clk);
        rst = r; rsp_ready = rr;
        req0_valid = v0; req0_ctrl = c0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_ctrl = c1; req1_a = a1; req1_b = b1;
        #1;
        room = !m_full || rr;
        win1 = (v0 && v1) ? !m_last : v1;
        e0 = !r && room && v0 && !win1;
        e1 = !r && room && v1 && win1;
        g0 = req0_ready; g1 = req1_ready;
        if (m_init) begin
            check_eq("req0_ready", {31'd0, req0_ready}, {31'd0, e0});
            check_eq("req1_ready", {31'd0, req1_ready}, {31'd0, e1});
            check_eq("rsp_valid",  {31'd0, rsp_valid},  {31'd0, m_full});
            check_eq("rsp_id",     {31'd0, rsp_id},     {31'd0, m_id});
            check_eq("rsp_result", rsp_result,          m_res);
            check_eq("rsp_zero",   {31'd0, rsp_zero},   {31'd0, m_zero});
        end
        @(posedge clk);
        if (r) begin
            m_init = 1; m_full = 0; m_id = 0; m_res = 0; m_zero = 0; m_last = 1;
        end else if (e0 || e1) begin
            m_res  = e1 ? ref_alu(c1, a1, b1) : ref_alu(c0, a0, b0);
            m_zero = (m_res == 0);
            m_id   = e1;
            m_last = e1;
            m_full = 1;
        end else if (rr) begin
            m_full = 0;
        end
    endtask

    task automatic expect_rsp(input string tag, input bit id, input logic [31:0] res, input bit z);
        #1;
        check_eq({tag, ".valid"},  {31'd0, rsp_valid}, 32'd1);
        check_eq({tag, ".id"},     {31'd0, rsp_id},    {31'd0, id});
        check_eq({tag, ".result"}, rsp_result,         res);
        check_eq({tag, ".zero"},   {31'd0, rsp_zero},  {31'd0, z});
    endtask

    bit          g0, g1;
    bit          p0v, p1v;
    logic [2:0]  p0c, p1c;
    logic [31:0] p0a, p0b, p1a, p1b;

    initial begin
        rst = 1; rsp_ready = 0;
        req0_valid = 0; req0_ctrl = 0; req0_a = 0; req0_b = 0;
        req1_valid = 0; req1_ctrl = 0; req1_a = 0; req1_b = 0;

        // Reset held with both requesters valid: nothing is ready.
        for (int i = 0; i < 2; i++) begin
            step(1, 1, ADD, 5, 7, 1, SHL, 1, 4, 1, g0, g1);
            check_eq("rst.rdy0", {31'd0, g0}, 32'd0);
            check_eq("rst.rdy1", {31'd0, g1}, 32'd0);
        end
        #1 check_eq("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);

        // First tie after reset goes to req0.
        step(0, 1, ADD, 5, 7, 1, SHL, 1, 4, 1, g0, g1);
        check_eq("tie0.rdy0", {31'd0, g0}, 32'd1);
        check_eq("tie0.rdy1", {31'd0, g1}, 32'd0);
        expect_rsp("tie0", 0, 32'd12, 0);

        // Single requester ADD 5+7.
        step(0, 1, ADD, 5, 7, 0, ADD, 0, 0, 1, g0, g1);
        check_eq("add.rdy0", {31'd0, g0}, 32'd1);
        expect_rsp("add", 0, 32'd12, 0);

        // Round-robin with both valid continuously, starting from reset.
        step(1, 0, ADD, 0, 0, 0, ADD, 0, 0, 1, g0, g1);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, SUB, 9, 9, 1, SHL, 1, 4, 1, g0, g1);
            check_eq("rr.rdy0", {31'd0, g0}, {31'd0, (i % 2 == 0)});
            check_eq("rr.rdy1", {31'd0, g1}, {31'd0, (i % 2 == 1)});
            if (i % 2 == 0) expect_rsp("rr.sub", 0, 32'd0, 1);
            else            expect_rsp("rr.shl", 1, 32'd16, 0);
        end

        // Backpressure: result held three cycles, then req1 accepted on release.
        for (int i = 0; i < 3; i++) begin
            step(0, 0, ADD, 0, 0, 1, ADD, 3, 4, 0, g0, g1);
            check_eq("bp.rdy1", {31'd0, g1}, 32'd0);
            expect_rsp("bp.hold", 1, 32'd16, 0);
        end
        step(0, 0, ADD, 0, 0, 1, ADD, 3, 4, 1, g0, g1);
        check_eq("bp.release", {31'd0, g1}, 32'd1);
        expect_rsp("bp.new", 1, 32'd7, 0);

        // Shift amount truncation and wrap-around edges.
        step(0, 1, SHR, 32'h8000_0000, 32'h23, 0, ADD, 0, 0, 1, g0, g1);
        expect_rsp("shr", 0, 32'h1000_0000, 0);
        step(0, 1, SUB, 0, 1, 0, ADD, 0, 0, 1, g0, g1);
        expect_rsp("sub_wrap", 0, 32'hFFFF_FFFF, 0);
        step(0, 1, NOTUSED, 5, 6, 0, ADD, 0, 0, 1, g0, g1);
        expect_rsp("notused", 0, 32'd0, 1);

        // Reset while FULL drops the result and restores req0 priority.
        step(0, 1, ADD, 1, 1, 1, ADD, 2, 2, 0, g0, g1);
        step(1, 1, ADD, 1, 1, 1, ADD, 2, 2, 0, g0, g1);
        #1 check_eq("midrst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        step(0, 1, ADD, 1, 1, 1, ADD, 2, 2, 1, g0, g1);
        check_eq("midrst.rdy0", {31'd0, g0}, 32'd1);
        expect_rsp("midrst", 0, 32'd2, 0);

        // Randomized traffic with held requests, stalls and occasional reset.
        p0v = 0; p1v = 0;
        p0c = 0; p1c = 0; p0a = 0; p0b = 0; p1a = 0; p1b = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!p0v && ($urandom % 3 != 0)) begin
                p0v = 1; p0c = 3'($urandom); p0a = $urandom;
                p0b = ($urandom % 4 == 0) ? p0a : $urandom;
            end
            if (!p1v && ($urandom % 3 != 0)) begin
                p1v = 1; p1c = 3'($urandom); p1a = $urandom;
                p1b = ($urandom % 4 == 0) ? p1a : $urandom;
            end
            step(($urandom % 64) == 0, p0v, p0c, p0a, p0b, p1v, p1c, p1a, p1b,
                 ($urandom % 4) != 0, g0, g1);
            if (g0) p0v = 0;
            if (g1) p1v = 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
